simon_key_schedule: RTL and testbench

//  Iterative SIMON-128/128 key expansion (m=2) feeding round keys to the round datapath inside top_simon.

---
 rtl/simon_key_schedule.sv | 114 +++++++++++
 tb/tb_simon_key_schedule.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_key_schedule.sv
// Iterative SIMON-128/128 key expansion: loads a 128-bit master key and streams
// round keys k[0]..k[N_ROUNDS-1] over a valid/ready handshake.
module simon_key_schedule #(
    parameter int          N_ROUNDS = 68,
    parameter logic [61:0] Z_SEQ    = 62'b10101111011100000011010010011000101000010001111110010110110011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] k0_i,
    output logic [63:0]  rk_o,
    output logic [6:0]   rk_idx_o,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic         rk_last_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [63:0] C_CONST  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [6:0]  LAST_IDX = 7'(N_ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [63:0] ka_reg, ka_next;
    logic [63:0] kb_reg, kb_next;
    logic [6:0]  cnt_reg, cnt_next;
    logic [5:0]  zidx_reg, zidx_next;

    logic [63:0] mix;
    logic [63:0] knew;
    logic        z_bit;
    logic        handshake;

    // Bitwise form of C ^ ka ^ ROR(kb,3) ^ ROR(kb,4): output bit i takes kb bits i+3 and i+4.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_mix
            assign mix[gi] = C_CONST[gi] ^ ka_reg[gi]
                           ^ kb_reg[(gi + 3) % 64] ^ kb_reg[(gi + 4) % 64];
        end
    endgenerate

    // z[0] sits in the MSB of Z_SEQ.
    assign z_bit     = Z_SEQ[6'd61 - zidx_reg];
    assign knew      = mix ^ {63'b0, z_bit};
    assign handshake = (state_reg == RUN) && rk_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ka_reg    <= '0;
            kb_reg    <= '0;
            cnt_reg   <= '0;
            zidx_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ka_reg    <= ka_next;
            kb_reg    <= kb_next;
            cnt_reg   <= cnt_next;
            zidx_reg  <= zidx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ka_next    = ka_reg;
        kb_next    = kb_reg;
        cnt_next   = cnt_reg;
        zidx_next  = zidx_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    ka_next    = k0_i[63:0];
                    kb_next    = k0_i[127:64];
                    cnt_next   = '0;
                    zidx_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (cnt_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        ka_next   = kb_reg;
                        kb_next   = knew;
                        cnt_next  = cnt_reg + 7'd1;
                        zidx_next = (zidx_reg == 6'd61) ? 6'd0 : zidx_reg + 6'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is a pure function of registered state; rk_ready_i never reaches an output.
    assign rk_o       = ka_reg;
    assign rk_idx_o   = cnt_reg;
    assign rk_valid_o = (state_reg == RUN);
    assign rk_last_o  = (state_reg == RUN) && (cnt_reg == LAST_IDX);
    assign busy_o     = (state_reg == RUN);
    assign done_o     = (state_reg == DONE);

endmodule

// File: tb/tb_simon_key_schedule.sv
// Scoreboard bench for simon_key_schedule: expected keys come from an array-based
// reference of the SIMON-128/128 schedule and are checked by an independent monitor.
module tb_simon_key_schedule;

    localparam int    NR     = 68;
    localparam int    TMO    = 2000;
    localparam string Z2_STR = "10101111011100000011010010011000101000010001111110010110110011";

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [127:0] k0_i;
    logic [63:0]  rk_o;
    logic [6:0]   rk_idx_o;
    logic         rk_valid_o;
    logic         rk_ready_i;
    logic         rk_last_o;
    logic         busy_o;
    logic         done_o;

    simon_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .k0_i       (k0_i),
        .rk_o       (rk_o),
        .rk_idx_o   (rk_idx_o),
        .rk_valid_o (rk_valid_o),
        .rk_ready_i (rk_ready_i),
        .rk_last_o  (rk_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  idx;
        logic [63:0] key;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model_keys[NR];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ror64(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [63:0] zterm(input int j);
        string s;
        s = Z2_STR;
        return (s[j] == "1") ? 64'd1 : 64'd0;
    endfunction

    // k[i+2] = c ^ k[i] ^ ROR(k[i+1],3) ^ ROR(k[i+1],4) ^ z[i mod 62]
    task automatic gen_model(input logic [127:0] key);
        model_keys[0] = key[63:0];
        model_keys[1] = key[127:64];
        for (int i = 0; i < NR - 2; i++) begin
            model_keys[i + 2] = 64'hFFFF_FFFF_FFFF_FFFC ^ model_keys[i]
                              ^ ror64(model_keys[i + 1], 3) ^ ror64(model_keys[i + 1], 4)
                              ^ zterm(i % 62);
        end
    endtask

    task automatic run_keys(input logic [127:0] key, input bit rand_ready, input bit consts,
                            input int inject_idx, input int rst_idx);
        int cyc;
        bit injected;
        exp_t e;
        gen_model(key);
        for (int i = 0; i < NR; i++) begin
            e.idx = 7'(i);
            e.key = model_keys[i];
            sb.push_back(e);
        end
        start_i    = 1'b1;
        k0_i       = key;
        rk_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("start_latency", 128'({rk_valid_o, busy_o, rk_idx_o}), 128'({1'b1, 1'b1, 7'd0}));
        check("first_key", 128'(rk_o), 128'(key[63:0]));
        cyc      = 0;
        injected = 1'b0;
        while (cyc < TMO) begin
            if (consts && cyc == 0) check("const_idx0", 128'(rk_o), 128'(64'h0706050403020100));
            if (consts && cyc == 1) check("const_idx1", 128'(rk_o), 128'(64'h0f0e0d0c0b0a0908));
            start_i    = 1'b0;
            rk_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject_idx >= 0 && !injected && rk_valid_o && int'(rk_idx_o) == inject_idx) begin
                start_i  = 1'b1;
                k0_i     = {$urandom, $urandom, $urandom, $urandom};
                injected = 1'b1;
            end
            if (rst_idx >= 0 && rk_valid_o && int'(rk_idx_o) == rst_idx) begin
                rst = 1'b1;
                sb.delete();
                #2;
                check("mid_run_reset_outputs",
                      128'({rk_valid_o, busy_o, done_o, rk_last_o, rk_o, rk_idx_o}), 128'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done_o) break;
        end
        start_i = 1'b0;
        if (cyc >= TMO) begin
            compared++;
            mismatched++;
            $display("FAIL run_timeout: got no done_o within %0d cycles, required done_o", TMO);
            sb.delete();
        end else begin
            check("queue_drained", 128'(sb.size()), 128'd0);
            if (!rand_ready && inject_idx < 0)
                check("done_latency", 128'(cyc), 128'(NR));
        end
        // DONE ignores start_i, so let the FSM settle back into IDLE first.
        @(posedge clk);
        #1;
    endtask

    logic [127:0] test_key;
    logic [63:0]  prev_rk;
    logic [6:0]   prev_idx;
    bit           prev_stall;
    bit           done_due;
    exp_t         got;

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        k0_i       = '0;
        rk_ready_i = 1'b0;
        prev_stall = 1'b0;
        done_due   = 1'b0;
        test_key   = 128'h0f0e0d0c0b0a0908_0706050403020100;
        fork
            begin : stimulus
                repeat (3) begin
                    @(negedge clk);
                    check("reset_outputs",
                          128'({rk_valid_o, busy_o, done_o, rk_last_o, rk_o, rk_idx_o}), 128'd0);
                end
                rst = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("idle_no_valid", 128'(rk_valid_o), 128'd0);
                end
                @(posedge clk);
                #1;
                run_keys(test_key, 1'b0, 1'b1, -1, -1);
                run_keys(test_key, 1'b1, 1'b0, -1, -1);
                run_keys({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 10, -1);
                run_keys(test_key, 1'b1, 1'b0, -1, 30);
                run_keys({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, -1, -1);
                run_keys({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1, -1);
                repeat (3) @(posedge clk);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_stall = 1'b0;
                        done_due   = 1'b0;
                    end else begin
                        if (done_due) begin
                            check("done_pulse", 128'(done_o), 128'd1);
                            done_due = 1'b0;
                        end else if (done_o) begin
                            check("done_unexpected", 128'(done_o), 128'd0);
                        end
                        if (prev_stall)
                            check("stall_stable", 128'({rk_valid_o, rk_idx_o, rk_o}),
                                  128'({1'b1, prev_idx, prev_rk}));
                        prev_stall = rk_valid_o && !rk_ready_i;
                        prev_rk    = rk_o;
                        prev_idx   = rk_idx_o;
                        if (rk_valid_o && rk_ready_i) begin
                            if (sb.size() == 0) begin
                                check("unexpected_key", 128'(rk_idx_o), 128'h7f);
                            end else begin
                                got = sb.pop_front();
                                $display("key idx=%0d rk=%h expected=%h", rk_idx_o, rk_o, got.key);
                                check("rk_idx", 128'(rk_idx_o), 128'(got.idx));
                                check("rk_key", 128'(rk_o), 128'(got.key));
                                check("rk_last", 128'(rk_last_o), 128'(got.idx == 7'(NR - 1)));
                                if (got.idx == 7'(NR - 1)) done_due = 1'b1;
                            end
                        end
                    end
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog: simulation still running, required completion");
                $fatal(1, "watchdog expired");
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
